// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: holds the core's pick until end of frame or
// timeout, then rotates the priority pointer past the winner.

module rnd_rb_scal #(
    parameter int unsigned RR_WIDTH    = 4,
    parameter int unsigned RR_WIDTH_L2 = $clog2(RR_WIDTH)
) (
    input  logic [RR_WIDTH-1:0]    rr_vec_in,
    input  logic [RR_WIDTH_L2-1:0] rr_priority,
    output logic [RR_WIDTH-1:0]    rr_vec_out,
    output logic [RR_WIDTH_L2-1:0] rr_bin_out
);

    // First set bit at or above rr_priority, wrapping modulo RR_WIDTH.
    always_comb begin : search
        logic                   found;
        logic [RR_WIDTH_L2-1:0] idx;
        rr_vec_out = '0;
        rr_bin_out = '0;
        found      = 1'b0;
        idx        = '0;
        for (int unsigned i = 0; i < RR_WIDTH; i++) begin
            idx = RR_WIDTH_L2'((32'(rr_priority) + i) % RR_WIDTH);
            if (!found && rr_vec_in[idx]) begin
                found           = 1'b1;
                rr_vec_out[idx] = 1'b1;
                rr_bin_out      = idx;
            end
        end
    end

endmodule

module rr_grant_ctrl #(
    parameter int unsigned RR_WIDTH    = 4,
    parameter int unsigned RR_WIDTH_L2 = $clog2(RR_WIDTH),
    parameter int unsigned TIMEOUT     = 2048,
    parameter int unsigned TO_WIDTH    = $clog2(TIMEOUT)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [RR_WIDTH-1:0]    req,
    input  logic                   gnt_done,
    output logic                   gnt_vld,
    output logic [RR_WIDTH-1:0]    gnt,
    output logic [RR_WIDTH_L2-1:0] gnt_bin,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [RR_WIDTH_L2-1:0] ptr_q, ptr_d;
    logic [TO_WIDTH-1:0]    cnt_q, cnt_d;
    logic                   gnt_vld_q, gnt_vld_d;
    logic [RR_WIDTH-1:0]    gnt_q, gnt_d;
    logic [RR_WIDTH_L2-1:0] gnt_bin_q, gnt_bin_d;
    logic                   timeout_err_q, timeout_err_d;

    logic [RR_WIDTH-1:0]    core_vec_c;
    logic [RR_WIDTH_L2-1:0] core_bin_c;
    logic [RR_WIDTH_L2-1:0] ptr_next_c;
    logic                   hold_expired_c;

    rnd_rb_scal #(
        .RR_WIDTH    (RR_WIDTH),
        .RR_WIDTH_L2 (RR_WIDTH_L2)
    ) u_core (
        .rr_vec_in   (req),
        .rr_priority (ptr_q),
        .rr_vec_out  (core_vec_c),
        .rr_bin_out  (core_bin_c)
    );

    // Explicit wrap keeps the pointer legal for non-power-of-two widths.
    assign ptr_next_c     = (gnt_bin_q == RR_WIDTH_L2'(RR_WIDTH - 1)) ? '0
                                                                      : gnt_bin_q + RR_WIDTH_L2'(1);
    assign hold_expired_c = (cnt_q == TO_WIDTH'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            gnt_vld_q     <= 1'b0;
            gnt_q         <= '0;
            gnt_bin_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            gnt_vld_q     <= gnt_vld_d;
            gnt_q         <= gnt_d;
            gnt_bin_q     <= gnt_bin_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        gnt_vld_d     = gnt_vld_q;
        gnt_d         = gnt_q;
        gnt_bin_d     = gnt_bin_q;
        timeout_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d     = core_vec_c;
                    gnt_bin_d = core_bin_c;
                    gnt_vld_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_GRANT;
                end
            end
            S_GRANT: begin
                // A done arriving on the expiry cycle wins over the timeout.
                if (gnt_done || hold_expired_c) begin
                    gnt_d         = '0;
                    gnt_bin_d     = '0;
                    gnt_vld_d     = 1'b0;
                    ptr_d         = ptr_next_c;
                    cnt_d         = '0;
                    timeout_err_d = !gnt_done;
                    state_d       = S_GAP;
                end else begin
                    cnt_d = cnt_q + TO_WIDTH'(1);
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt_vld     = gnt_vld_q;
    assign gnt         = gnt_q;
    assign gnt_bin     = gnt_bin_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl (4 ports, TIMEOUT shortened to 16).

module tb_rr_grant_ctrl;

    logic       clk;
    logic       rstn;
    logic [3:0] req;
    logic       gnt_done;
    logic       gnt_vld;
    logic [3:0] gnt;
    logic [1:0] gnt_bin;
    logic       timeout_err;

    int n_pass  = 0;
    int n_total = 0;

    // Observed tuple {gnt_vld, gnt, gnt_bin, timeout_err}.
    logic [7:0] obs;

    rr_grant_ctrl #(
        .RR_WIDTH (4),
        .TIMEOUT  (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .gnt_done    (gnt_done),
        .gnt_vld     (gnt_vld),
        .gnt         (gnt),
        .gnt_bin     (gnt_bin),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        req      = '0;
        gnt_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    // Pulse gnt_done for one cycle, then wait out GAP so the next tick arbitrates.
    task automatic release_grant();
        gnt_done = 1'b1;
        tick();
        gnt_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        req      = 4'b1111;
        gnt_done = 1'b0;
        #12;
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b0_0000_00_0)
            $display("FAIL reset_state: got %b expected %b", obs, 8'b0_0000_00_0);
        else n_pass++;
        do_reset();
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b0_0000_00_0)
            $display("FAIL reset_release_idle: got %b expected %b", obs, 8'b0_0000_00_0);
        else n_pass++;
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g [5];
        logic [1:0] exp_b [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_b = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            obs = {gnt_vld, gnt, gnt_bin, timeout_err};
            n_total++;
            if (obs !== {1'b1, exp_g[k], exp_b[k], 1'b0})
                $display("FAIL rotation_grant%0d: got %b expected %b", k, obs, {1'b1, exp_g[k], exp_b[k], 1'b0});
            else n_pass++;
            tick();
            tick();
            gnt_done = 1'b1;
            tick();
            gnt_done = 1'b0;
            obs = {gnt_vld, gnt, gnt_bin, timeout_err};
            n_total++;
            if (obs !== 8'b0_0000_00_0)
                $display("FAIL rotation_gap%0d: got %b expected %b", k, obs, 8'b0_0000_00_0);
            else n_pass++;
            tick();
            n_total++;
            if (gnt_vld !== 1'b0)
                $display("FAIL rotation_idle%0d: got %b expected 0", k, gnt_vld);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0011;
        tick();
        release_grant();
        tick();
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b1_0010_01_0)
            $display("FAIL wrap_setup_port1: got %b expected %b", obs, 8'b1_0010_01_0);
        else n_pass++;
        release_grant();
        tick();
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b1_0001_00_0)
            $display("FAIL wrap_search_port0: got %b expected %b", obs, 8'b1_0001_00_0);
        else n_pass++;
        release_grant();
        tick();
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b1_0010_01_0)
            $display("FAIL wrap_ptr_after: got %b expected %b", obs, 8'b1_0010_01_0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int hold;
        do_reset();
        req = 4'b0100;
        tick();
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b1_0100_10_0)
            $display("FAIL timeout_grant: got %b expected %b", obs, 8'b1_0100_10_0);
        else n_pass++;
        req  = 4'b1100;
        hold = 1;
        while (gnt_vld === 1'b1 && hold < 40) begin
            tick();
            if (gnt_vld === 1'b1) hold++;
        end
        n_total++;
        if (hold != 16)
            $display("FAIL timeout_hold_cycles: got %0d expected 16", hold);
        else n_pass++;
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b0_0000_00_1)
            $display("FAIL timeout_release: got %b expected %b", obs, 8'b0_0000_00_1);
        else n_pass++;
        tick();
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b0_0000_00_0)
            $display("FAIL timeout_pulse_width: got %b expected %b", obs, 8'b0_0000_00_0);
        else n_pass++;
        tick();
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b1_1000_11_0)
            $display("FAIL timeout_next_port3: got %b expected %b", obs, 8'b1_1000_11_0);
        else n_pass++;
    endtask

    task automatic test_req_change();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            obs = {gnt_vld, gnt, gnt_bin, timeout_err};
            n_total++;
            if (obs !== 8'b1_0010_01_0)
                $display("FAIL req_change_hold%0d: got %b expected %b", k, obs, 8'b1_0010_01_0);
            else n_pass++;
            tick();
        end
        gnt_done = 1'b1;
        tick();
        gnt_done = 1'b0;
        n_total++;
        if (gnt_vld !== 1'b0)
            $display("FAIL req_change_gap: got %b expected 0", gnt_vld);
        else n_pass++;
        tick();
        tick();
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b1_1000_11_0)
            $display("FAIL req_change_next: got %b expected %b", obs, 8'b1_1000_11_0);
        else n_pass++;
    endtask

    task automatic test_done_corner();
        do_reset();
        gnt_done = 1'b1;
        tick();
        gnt_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            obs = {gnt_vld, gnt, gnt_bin, timeout_err};
            n_total++;
            if (obs !== 8'b0_0000_00_0)
                $display("FAIL done_in_idle%0d: got %b expected %b", k, obs, 8'b0_0000_00_0);
            else n_pass++;
            tick();
        end
        req = 4'b0010;
        tick();
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b1_0010_01_0)
            $display("FAIL done_corner_grant: got %b expected %b", obs, 8'b1_0010_01_0);
        else n_pass++;
        repeat (15) tick();
        gnt_done = 1'b1;
        tick();
        gnt_done = 1'b0;
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b0_0000_00_0)
            $display("FAIL done_at_timeout: got %b expected %b", obs, 8'b0_0000_00_0);
        else n_pass++;
        tick();
        n_total++;
        if (timeout_err !== 1'b0)
            $display("FAIL done_at_timeout_late_err: got %b expected 0", timeout_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0010;
        tick();
        release_grant();
        req = 4'b0100;
        tick();
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b1_0100_10_0)
            $display("FAIL midrst_grant: got %b expected %b", obs, 8'b1_0100_10_0);
        else n_pass++;
        #2;
        rstn = 1'b0;
        #1;
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b0_0000_00_0)
            $display("FAIL midrst_async_clear: got %b expected %b", obs, 8'b0_0000_00_0);
        else n_pass++;
        @(negedge clk);
        req  = 4'b1111;
        rstn = 1'b1;
        tick();
        obs = {gnt_vld, gnt, gnt_bin, timeout_err};
        n_total++;
        if (obs !== 8'b1_0001_00_0)
            $display("FAIL midrst_ptr_zero: got %b expected %b", obs, 8'b1_0001_00_0);
        else n_pass++;
    endtask

    initial begin
        rstn     = 1'b0;
        req      = '0;
        gnt_done = 1'b0;
        test_reset();
        test_rotation();
        test_wrap();
        test_timeout();
        test_req_change();
        test_done_corner();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
